// File: rtl/mat_mult_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mat_mult_pkg : shared types and width helpers for the matrix-multiply ctrl  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package mat_mult_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // Index/address fields never shrink below one bit, even for a size of 1.
   function automatic int addr_w(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   localparam int DEF_M    = 2;
   localparam int DEF_K    = 2;
   localparam int DEF_N    = 2;
   localparam int DEF_AW_A = addr_w(DEF_M * DEF_K);
   localparam int DEF_AW_B = addr_w(DEF_K * DEF_N);
   localparam int DEF_AW_C = addr_w(DEF_M * DEF_N);

endpackage
`default_nettype wire

// File: rtl/mat_mult_ctrl_gen_delay_line.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ctrl_delay_line : aligns MAC/C-write tags with the A/B memory read latency  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module ctrl_delay_line #(
   parameter int DEPTH = 1,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          i_clear,
   input  logic          i_valid,
   input  logic          i_first,
   input  logic          i_last,
   input  logic [AW-1:0] i_addr,
   output logic          o_valid,
   output logic          o_first,
   output logic          o_last,
   output logic [AW-1:0] o_addr,
   output logic          o_any_valid
);
   localparam int SW = AW + 3;

   logic [SW-1:0] r_stage [DEPTH];

   always_ff @(posedge clk) begin
      if (i_clear) begin
         for (int s = 0; s < DEPTH; s++) r_stage[s] <= '0;
      end else begin
         r_stage[0] <= {i_valid, i_first, i_last, i_addr};
         for (int s = 1; s < DEPTH; s++) r_stage[s] <= r_stage[s-1];
      end
   end

   assign {o_valid, o_first, o_last, o_addr} = r_stage[DEPTH-1];

   // Any tag still in flight keeps the controller draining.
   always_comb begin
      o_any_valid = 1'b0;
      for (int s = 0; s < DEPTH; s++) o_any_valid = o_any_valid | r_stage[s][SW-1];
   end

endmodule
`default_nettype wire

// File: rtl/mat_mult_ctrl_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mat_mult_ctrl_gen : address/strobe sequencer for C = A x B on one MAC unit  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module mat_mult_ctrl_gen
   import mat_mult_pkg::*;
#(
   parameter int  M       = 2,
   parameter int  K       = 2,
   parameter int  N       = 2,
   parameter int  MEM_LAT = 1,
   parameter int  CNT_W   = 11,
   localparam int AW_A    = addr_w(M * K),
   localparam int AW_B    = addr_w(K * N),
   localparam int AW_C    = addr_w(M * N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   output logic             rd_en,
   output logic [AW_A-1:0]  addr_a,
   output logic [AW_B-1:0]  addr_b,
   output logic             mac_en,
   output logic             mac_clr,
   output logic             c_we,
   output logic [AW_C-1:0]  c_addr,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] clock_count
);
   localparam int IW = addr_w(M);
   localparam int JW = addr_w(N);
   localparam int KW = addr_w(K);

   if (M < 1 || K < 1 || N < 1 || MEM_LAT < 1) begin : g_param_check
      $error("mat_mult_ctrl_gen: M, K, N and MEM_LAT must all be >= 1");
   end

   state_t            r_state, w_state_n;
   logic [IW-1:0]     r_i, w_i_n;
   logic [JW-1:0]     r_j, w_j_n;
   logic [KW-1:0]     r_k, w_k_n;
   logic              w_issue, w_accept, w_cancel, w_last_issue, w_busy_n;
   logic              r_rd_en, r_c_we, r_busy, r_done;
   logic [AW_A-1:0]   r_addr_a, w_addr_a;
   logic [AW_B-1:0]   r_addr_b, w_addr_b;
   logic [AW_C-1:0]   r_c_addr, w_in_addr, w_dl_addr;
   logic              w_dl_valid, w_dl_first, w_dl_last, w_dl_any, w_dl_clear, w_write;
   logic [CNT_W-1:0]  r_count;

   assign w_last_issue = (r_i == IW'(M - 1)) && (r_j == JW'(N - 1)) && (r_k == KW'(K - 1));

   always_comb begin
      w_state_n = r_state;
      w_i_n     = r_i;
      w_j_n     = r_j;
      w_k_n     = r_k;
      w_issue   = 1'b0;
      w_accept  = 1'b0;
      w_cancel  = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start && !abort) begin
               w_state_n = RUN;
               w_accept  = 1'b1;
               w_issue   = 1'b1;
               w_i_n     = '0;
               w_j_n     = '0;
               w_k_n     = '0;
            end else begin
               w_state_n = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               w_state_n = IDLE;
               w_cancel  = 1'b1;
            end else if (w_last_issue) begin
               w_state_n = DRAIN;
            end else begin
               // k runs fastest, then j, then i.
               w_issue = 1'b1;
               if (r_k == KW'(K - 1)) begin
                  w_k_n = '0;
                  if (r_j == JW'(N - 1)) begin
                     w_j_n = '0;
                     w_i_n = r_i + 1'b1;
                  end else begin
                     w_j_n = r_j + 1'b1;
                  end
               end else begin
                  w_k_n = r_k + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (abort) begin
               w_state_n = IDLE;
               w_cancel  = 1'b1;
            end else if (!w_dl_any) begin
               w_state_n = DONE;
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   assign w_busy_n  = (w_state_n == RUN) || (w_state_n == DRAIN);
   assign w_addr_a  = AW_A'(int'(w_i_n) * K + int'(w_k_n));
   assign w_addr_b  = AW_B'(int'(w_k_n) * N + int'(w_j_n));
   assign w_in_addr = r_rd_en ? AW_C'(int'(r_i) * N + int'(r_j)) : '0;
   assign w_dl_clear = reset || w_cancel;
   assign w_write   = w_dl_valid && w_dl_last && !w_cancel;

   ctrl_delay_line #(
      .DEPTH (MEM_LAT),
      .AW    (AW_C)
   ) u_delay (
      .clk         (clk),
      .i_clear     (w_dl_clear),
      .i_valid     (r_rd_en),
      .i_first     (r_rd_en && (r_k == '0)),
      .i_last      (r_rd_en && (r_k == KW'(K - 1))),
      .i_addr      (w_in_addr),
      .o_valid     (w_dl_valid),
      .o_first     (w_dl_first),
      .o_last      (w_dl_last),
      .o_addr      (w_dl_addr),
      .o_any_valid (w_dl_any)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_i      <= '0;
         r_j      <= '0;
         r_k      <= '0;
         r_rd_en  <= 1'b0;
         r_addr_a <= '0;
         r_addr_b <= '0;
         r_c_we   <= 1'b0;
         r_c_addr <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_count  <= '0;
      end else begin
         r_state  <= w_state_n;
         r_i      <= w_i_n;
         r_j      <= w_j_n;
         r_k      <= w_k_n;
         r_rd_en  <= w_issue;
         r_addr_a <= w_issue ? w_addr_a : '0;
         r_addr_b <= w_issue ? w_addr_b : '0;
         r_c_we   <= w_write;
         r_c_addr <= w_write ? w_dl_addr : '0;
         r_busy   <= w_busy_n;
         r_done   <= (w_state_n == DONE);
         // The accepting edge already opens the first busy cycle.
         if (w_accept) begin
            r_count <= CNT_W'(1);
         end else if (w_busy_n && !(&r_count)) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign rd_en       = r_rd_en;
   assign addr_a      = r_addr_a;
   assign addr_b      = r_addr_b;
   assign mac_en      = w_dl_valid;
   assign mac_clr     = w_dl_valid && w_dl_first;
   assign c_we        = r_c_we;
   assign c_addr      = r_c_addr;
   assign busy        = r_busy;
   assign done        = r_done;
   assign clock_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mat_mult_ctrl_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mat_mult_ctrl_gen : three configurations driven in lockstep vs a model   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_mat_mult_ctrl_gen;

   localparam int BIG = 1 << 30;

   typedef struct {
      int rd_en, addr_a, addr_b, mac_en, mac_clr, c_we, c_addr, busy, done, count;
   } exp_t;

   logic clk = 1'b0;
   logic reset, start, abort;

   logic        rd_en1, mac_en1, mac_clr1, c_we1, busy1, done1;
   logic [1:0]  addr_a1, addr_b1, c_addr1;
   logic [10:0] cnt1;

   logic        rd_en5, mac_en5, mac_clr5, c_we5, busy5, done5;
   logic [1:0]  addr_a5;
   logic [0:0]  addr_b5;
   logic [2:0]  c_addr5;
   logic [10:0] cnt5;

   logic        rd_en6, mac_en6, mac_clr6, c_we6, busy6, done6;
   logic [1:0]  addr_a6, addr_b6, c_addr6;
   logic [2:0]  cnt6;

   int cyc     = 0;
   int n_tests = 0;
   int n_fail  = 0;
   int m_t0    = -1;
   int m_cut   = BIG;
   int run_c0  = 0;
   bit chk_on  = 1'b0;

   int lit_a [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
   int lit_b [8] = '{0, 2, 1, 3, 0, 2, 1, 3};

   always #5 clk = ~clk;

   mat_mult_ctrl_gen #(.M(2), .K(2), .N(2), .MEM_LAT(1), .CNT_W(11)) dut1 (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .rd_en(rd_en1), .addr_a(addr_a1), .addr_b(addr_b1), .mac_en(mac_en1),
      .mac_clr(mac_clr1), .c_we(c_we1), .c_addr(c_addr1), .busy(busy1),
      .done(done1), .clock_count(cnt1));

   mat_mult_ctrl_gen #(.M(3), .K(1), .N(2), .MEM_LAT(3), .CNT_W(11)) dut5 (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .rd_en(rd_en5), .addr_a(addr_a5), .addr_b(addr_b5), .mac_en(mac_en5),
      .mac_clr(mac_clr5), .c_we(c_we5), .c_addr(c_addr5), .busy(busy5),
      .done(done5), .clock_count(cnt5));

   mat_mult_ctrl_gen #(.M(2), .K(2), .N(2), .MEM_LAT(1), .CNT_W(3)) dut6 (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .rd_en(rd_en6), .addr_a(addr_a6), .addr_b(addr_b6), .mac_en(mac_en6),
      .mac_clr(mac_clr6), .c_we(c_we6), .c_addr(c_addr6), .busy(busy6),
      .done(done6), .clock_count(cnt6));

   // Expected outputs at cycle c for a run accepted at t0 and cancelled after cycle cut.
   function automatic exp_t model(input int c, input int t0, input int cut, input int m,
                                  input int k, input int n, input int l, input int cw);
      exp_t e;
      int tot, blast, cc, s;
      e = '{default: 0};
      if (t0 < 0) return e;
      tot   = m * k * n;
      blast = t0 + tot + l + 1;
      cc = (c > cut) ? cut : c;
      if (cc > blast) cc = blast;
      e.count = cc - t0;
      if (e.count > (1 << cw) - 1) e.count = (1 << cw) - 1;
      if (c > cut) return e;
      s = c - t0 - 1;
      if (s >= 0 && s < tot) begin
         e.rd_en  = 1;
         e.addr_a = (s / (k * n)) * k + s % k;
         e.addr_b = (s % k) * n + (s / k) % n;
      end
      s = c - t0 - 1 - l;
      if (s >= 0 && s < tot) begin
         e.mac_en  = 1;
         e.mac_clr = (s % k == 0) ? 1 : 0;
      end
      s = c - t0 - 2 - l;
      if (s >= 0 && s < tot && s % k == k - 1) begin
         e.c_we   = 1;
         e.c_addr = s / k;
      end
      e.busy = (c > t0 && c <= blast) ? 1 : 0;
      e.done = (c == blast + 1) ? 1 : 0;
      return e;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input int exp);
      n_tests++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
      end
   endtask

   task automatic check_dut(input string tag, input exp_t e,
                            input logic [31:0] rd, aa, ab, me, mc, we, ca, bz, dn, ct);
      check({tag, ".rd_en"},   rd, e.rd_en);
      check({tag, ".addr_a"},  aa, e.addr_a);
      check({tag, ".addr_b"},  ab, e.addr_b);
      check({tag, ".mac_en"},  me, e.mac_en);
      check({tag, ".mac_clr"}, mc, e.mac_clr);
      check({tag, ".c_we"},    we, e.c_we);
      check({tag, ".c_addr"},  ca, e.c_addr);
      check({tag, ".busy"},    bz, e.busy);
      check({tag, ".done"},    dn, e.done);
      check({tag, ".count"},   ct, e.count);
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check_dut("d1", model(cyc, m_t0, m_cut, 2, 2, 2, 1, 11),
                   32'(rd_en1), 32'(addr_a1), 32'(addr_b1), 32'(mac_en1), 32'(mac_clr1),
                   32'(c_we1), 32'(c_addr1), 32'(busy1), 32'(done1), 32'(cnt1));
         check_dut("d5", model(cyc, m_t0, m_cut, 3, 1, 2, 3, 11),
                   32'(rd_en5), 32'(addr_a5), 32'(addr_b5), 32'(mac_en5), 32'(mac_clr5),
                   32'(c_we5), 32'(c_addr5), 32'(busy5), 32'(done5), 32'(cnt5));
         check_dut("d6", model(cyc, m_t0, m_cut, 2, 2, 2, 1, 3),
                   32'(rd_en6), 32'(addr_a6), 32'(addr_b6), 32'(mac_en6), 32'(mac_clr6),
                   32'(c_we6), 32'(c_addr6), 32'(busy6), 32'(done6), 32'(cnt6));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // start is high during the current cycle; the run is live from the next one.
   task automatic start_run();
      start  = 1'b1;
      run_c0 = cyc;
      tick();
      start  = 1'b0;
      m_t0   = run_c0;
      m_cut  = BIG;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      tick();
      chk_on = 1'b1;
      tick();
      reset = 1'b0;
      check("reset.busy",  32'(busy1), 0);
      check("reset.rd_en", 32'(rd_en1), 0);
      check("reset.count", 32'(cnt1), 0);
      tick();

      // Basic run on all three configurations, with literal sequence pins.
      start_run();
      for (int rel = 1; rel <= 12; rel++) begin
         if (rel > 1) tick();
         if (rel <= 8) begin
            check("t1.addr_a", 32'(addr_a1), lit_a[rel-1]);
            check("t1.addr_b", 32'(addr_b1), lit_b[rel-1]);
         end
         check("t1.mac_clr", 32'(mac_clr1), (rel % 2 == 0 && rel <= 8) ? 1 : 0);
         check("t1.c_we", 32'(c_we1), (rel % 2 == 0 && rel >= 4 && rel <= 10) ? 1 : 0);
         if (rel % 2 == 0 && rel >= 4 && rel <= 10) check("t1.c_addr", 32'(c_addr1), rel / 2 - 2);
         check("t1.done", 32'(done1), (rel == 11) ? 1 : 0);
         check("t5.mac_clr", 32'(mac_clr5), (rel >= 4 && rel <= 9) ? 1 : 0);
         check("t5.c_we", 32'(c_we5), (rel >= 5 && rel <= 10) ? 1 : 0);
         if (rel >= 5 && rel <= 10) check("t5.c_addr", 32'(c_addr5), rel - 5);
         if (rel == 7) check("t6.count_sat", 32'(cnt6), 7);
         if (rel == 11) begin
            check("t1.count", 32'(cnt1), 10);
            check("t5.count", 32'(cnt5), 10);
            check("t6.count", 32'(cnt6), 7);
         end
      end
      repeat (2) tick();

      // Back-to-back: start raised in the done cycle.
      start_run();
      repeat (10) tick();
      check("t2.done_first", 32'(done1), 1);
      start_run();
      check("t2.count_cleared", 32'(cnt1), 1);
      check("t2.rd_en", 32'(rd_en1), 1);
      repeat (10) tick();
      check("t2.done_second", 32'(done1), 1);
      check("t2.count", 32'(cnt1), 10);
      repeat (2) tick();

      // Abort during cycle 5 of a run.
      start_run();
      repeat (4) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      m_cut = run_c0 + 5;
      check("t3.c_we", 32'(c_we1), 0);
      check("t3.busy", 32'(busy1), 0);
      check("t3.count", 32'(cnt1), 5);
      repeat (8) tick();
      check("t3.count_hold", 32'(cnt1), 5);

      // Reset during cycle 6 of a run, then a clean run.
      start_run();
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_t0  = -1;
      check("t4.rd_en", 32'(rd_en1), 0);
      check("t4.count", 32'(cnt1), 0);
      repeat (2) tick();
      start_run();
      repeat (10) tick();
      check("t4.done", 32'(done1), 1);
      check("t4.count_after", 32'(cnt1), 10);
      repeat (2) tick();

      // start pulses while busy are ignored.
      start_run();
      for (int rel = 2; rel <= 12; rel++) begin
         tick();
         start = (rel == 3 || rel == 8) ? 1'b1 : 1'b0;
         if (rel == 11) begin
            check("t6b.done", 32'(done1), 1);
            check("t6b.count", 32'(cnt1), 10);
         end
      end
      start = 1'b0;
      repeat (2) tick();

      // abort together with start in IDLE: abort wins.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("t7.busy", 32'(busy1), 0);
      check("t7.rd_en", 32'(rd_en1), 0);
      repeat (3) tick();

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
